// File: rtl/regfile_mp.sv
// Multi-read-port register file built from replicated distributed RAMs sharing one write port,
// with a post-reset clear sequence, optional hardwired-zero register 0 and optional write bypass.

module sdp_dist_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

module regfile_mp #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG0  = 1,
    parameter int BYPASS     = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_stall,
    input  logic                                   i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]               i_wr_addr,
    input  logic [DATA_WIDTH-1:0]                  i_wr_data,
    input  logic [NUM_READ*$clog2(DEPTH)-1:0]      i_rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]         o_rd_data,
    output logic                                   o_init_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);

    // Write contract: no handshake. A write is taken on the rising edge when, in READY,
    // i_wr_en is high, i_stall is low, the address is in range and is not a hardwired zero.
    // o_init_busy doubles as the state observation point: high exactly while state is CLEAR.
    typedef enum logic {CLEAR, READY} state_t;

    state_t                state, state_nxt;
    logic [AW:0]           clr_addr, clr_addr_nxt;
    logic                  we;
    logic                  ram_we;
    logic [AW-1:0]         ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  wr_in_range;
    logic                  wr_is_zero;

    assign wr_in_range = ({1'b0, i_wr_addr} < DEPTH_W);
    assign wr_is_zero  = (ZERO_REG0 != 0) && (i_wr_addr == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        we           = 1'b0;
        ram_we       = 1'b0;
        ram_wr_addr  = i_wr_addr;
        ram_wr_data  = i_wr_data;
        case (state)
            CLEAR: begin
                // The clearer owns the write port; external requests are dropped.
                ram_we       = 1'b1;
                ram_wr_addr  = clr_addr[AW-1:0];
                ram_wr_data  = '0;
                clr_addr_nxt = clr_addr + (AW+1)'(1);
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                we     = i_wr_en & ~i_stall & wr_in_range & ~wr_is_zero;
                ram_we = we;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign o_init_busy = (state == CLEAR);

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] ram_q;
        logic [DATA_WIDTH-1:0] data;

        assign addr = i_rd_addr[k*AW +: AW];

        sdp_dist_ram #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ram (
            .clk     (i_clk),
            .we      (ram_we),
            .wr_addr (ram_wr_addr),
            .wr_data (ram_wr_data),
            .rd_addr (addr),
            .rd_data (ram_q)
        );

        // RAM contents are undefined until the clear completes, so mask them while busy.
        always_comb begin
            data = ram_q;
            if (state == CLEAR) begin
                data = '0;
            end else if ({1'b0, addr} >= DEPTH_W) begin
                data = '0;
            end else if ((ZERO_REG0 != 0) && (addr == '0)) begin
                data = '0;
            end else if ((BYPASS != 0) && we && (i_wr_addr == addr)) begin
                data = i_wr_data;
            end
        end

        assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
    end

endmodule
